// File: rtl/alu32.sv
// Registered 32-bit integer ALU: arithmetic, multiply, logic, shifts and compares, one-cycle latency.
// Optional combinational unsigned divider on opcode 01111 when ALU_DIV_EN is defined.
module alu32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] operand0,
    input  logic [WIDTH-1:0] operand1,
    input  logic             cin,
    output logic [WIDTH-1:0] result0,
    output logic [WIDTH-1:0] result1,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_ADDC  = 5'b00001;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_MULU  = 5'b00011;
    localparam logic [4:0] OP_MULS  = 5'b00100;
    localparam logic [4:0] OP_AND   = 5'b00101;
    localparam logic [4:0] OP_OR    = 5'b00110;
    localparam logic [4:0] OP_XOR   = 5'b00111;
    localparam logic [4:0] OP_NOR   = 5'b01000;
    localparam logic [4:0] OP_NOT   = 5'b01001;
    localparam logic [4:0] OP_SLL   = 5'b01010;
    localparam logic [4:0] OP_SRL   = 5'b01011;
    localparam logic [4:0] OP_SRA   = 5'b01100;
    localparam logic [4:0] OP_SLT   = 5'b01101;
    localparam logic [4:0] OP_SLTU  = 5'b01110;
`ifdef ALU_DIV_EN
    localparam logic [4:0] OP_DIVU  = 5'b01111;
`endif
    localparam logic [4:0] OP_SUBB  = 5'b10000;
    localparam logic [4:0] OP_PASSB = 5'b10001;

    logic             w_cin_add;
    logic             w_cin_sub;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [4:0]       w_shamt;
    logic [2*WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;

    assign w_cin_add = (opcode == OP_ADDC) & cin;
    assign w_cin_sub = (opcode == OP_SUBB) & cin;
    assign w_shamt   = operand1[4:0];

    // Bit WIDTH of the widened difference is set exactly when A < B + cin (borrow).
    assign w_add = {1'b0, operand0} + {1'b0, operand1} + (WIDTH+1)'(w_cin_add);
    assign w_sub = {1'b0, operand0} - {1'b0, operand1} - (WIDTH+1)'(w_cin_sub);

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDC: begin
                w_res[WIDTH-1:0] = w_add[WIDTH-1:0];
                w_carry = w_add[WIDTH];
                w_ovf   = (operand0[WIDTH-1] == operand1[WIDTH-1]) &&
                          (w_add[WIDTH-1] != operand0[WIDTH-1]);
            end
            OP_SUB, OP_SUBB: begin
                w_res[WIDTH-1:0] = w_sub[WIDTH-1:0];
                w_carry = w_sub[WIDTH];
                w_ovf   = (operand0[WIDTH-1] != operand1[WIDTH-1]) &&
                          (w_sub[WIDTH-1] != operand0[WIDTH-1]);
            end
            OP_MULU: w_res = {{WIDTH{1'b0}}, operand0} * {{WIDTH{1'b0}}, operand1};
            OP_MULS: w_res = $signed({{WIDTH{operand0[WIDTH-1]}}, operand0}) *
                             $signed({{WIDTH{operand1[WIDTH-1]}}, operand1});
            OP_AND:  w_res[WIDTH-1:0] = operand0 & operand1;
            OP_OR:   w_res[WIDTH-1:0] = operand0 | operand1;
            OP_XOR:  w_res[WIDTH-1:0] = operand0 ^ operand1;
            OP_NOR:  w_res[WIDTH-1:0] = ~(operand0 | operand1);
            OP_NOT:  w_res[WIDTH-1:0] = ~operand0;
            OP_SLL:  w_res[WIDTH-1:0] = operand0 << w_shamt;
            OP_SRL:  w_res[WIDTH-1:0] = operand0 >> w_shamt;
            OP_SRA:  w_res[WIDTH-1:0] = $signed(operand0) >>> w_shamt;
            OP_SLT:  w_res[WIDTH-1:0] = WIDTH'($signed(operand0) < $signed(operand1));
            OP_SLTU: w_res[WIDTH-1:0] = WIDTH'(operand0 < operand1);
`ifdef ALU_DIV_EN
            OP_DIVU: begin
                if (operand1 == '0) begin
                    w_res = {operand0, {WIDTH{1'b1}}};
                    w_ovf = 1'b1;
                end else begin
                    w_res = {operand0 % operand1, operand0 / operand1};
                end
            end
`endif
            OP_PASSB: w_res[WIDTH-1:0] = operand1;
            default:  w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result0  <= '0;
            result1  <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            result0  <= w_res[WIDTH-1:0];
            result1  <= w_res[2*WIDTH-1:WIDTH];
            carry    <= w_carry;
            overflow <= w_ovf;
            zero     <= (w_res == '0);
        end
    end

endmodule

// File: tb/tb_alu32.sv
// Scoreboard bench for alu32: directed vectors plus random ops against an arithmetic reference model.
module tb_alu32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  opcode;
    logic [31:0] operand0, operand1;
    logic        cin;
    logic [31:0] result0, result1;
    logic        carry, overflow, zero;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] r0;
        logic [31:0] r1;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    exp_t q[$];

    alu32 dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .operand0(operand0),
        .operand1(operand1), .cin(cin), .result0(result0), .result1(result1),
        .carry(carry), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic c);
        exp_t e;
        longint sa, sb, sr, lim;
        logic [63:0] ua, ub, ur;
        e.op = op; e.r0 = '0; e.r1 = '0; e.c = 1'b0; e.v = 1'b0;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lim = 2147483647;
        case (op)
            5'd0, 5'd1: begin
                ur = ua + ub + ((op == 5'd1) ? 64'(c) : 64'd0);
                sr = sa + sb + ((op == 5'd1) ? longint'(c) : 0);
                e.r0 = ur[31:0];
                e.c  = ur > 64'hFFFF_FFFF;
                e.v  = (sr > lim) || (sr < -lim - 1);
            end
            5'd2, 5'd16: begin
                ur = ub + ((op == 5'd16) ? 64'(c) : 64'd0);
                sr = sa - sb - ((op == 5'd16) ? longint'(c) : 0);
                e.r0 = 32'(ua - ur);
                e.c  = ua < ur;
                e.v  = (sr > lim) || (sr < -lim - 1);
            end
            5'd3: begin ur = ua * ub; e.r0 = ur[31:0]; e.r1 = ur[63:32]; end
            5'd4: begin sr = sa * sb; ur = 64'(sr); e.r0 = ur[31:0]; e.r1 = ur[63:32]; end
            5'd5:  e.r0 = a & b;
            5'd6:  e.r0 = a | b;
            5'd7:  e.r0 = a ^ b;
            5'd8:  e.r0 = ~(a | b);
            5'd9:  e.r0 = ~a;
            5'd10: e.r0 = a << b[4:0];
            5'd11: e.r0 = a >> b[4:0];
            5'd12: e.r0 = 32'(sa >>> b[4:0]);
            5'd13: e.r0 = (sa < sb) ? 32'd1 : 32'd0;
            5'd14: e.r0 = (ua < ub) ? 32'd1 : 32'd0;
`ifdef ALU_DIV_EN
            5'd15: begin
                if (b == 0) begin e.r0 = 32'hFFFF_FFFF; e.r1 = a; e.v = 1'b1; end
                else begin e.r0 = a / b; e.r1 = a % b; end
            end
`endif
            5'd17: e.r0 = b;
            default: ;
        endcase
        e.z = ({e.r1, e.r0} == 64'd0);
        return e;
    endfunction

    task automatic issue(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
        @(negedge clk);
        opcode = op; operand0 = a; operand1 = b; cin = c;
        q.push_back(model(op, a, b, c));
    endtask

    // Monitor: every edge out of reset retires the op launched on the previous negedge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst_n && q.size() > 0) begin
                #1;
                e = q.pop_front();
                chk($sformatf("r0 op%0d", e.op), 64'(result0), 64'(e.r0));
                chk($sformatf("r1 op%0d", e.op), 64'(result1), 64'(e.r1));
                chk($sformatf("carry op%0d", e.op), 64'(carry), 64'(e.c));
                chk($sformatf("ovf op%0d", e.op), 64'(overflow), 64'(e.v));
                chk($sformatf("zero op%0d", e.op), 64'(zero), 64'(e.z));
            end
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int wait_cyc;
        rst_n = 1'b0;
        opcode = 5'd3; operand0 = 32'h1234_5678; operand1 = 32'h9ABC_DEF0; cin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst r0", 64'(result0), 64'd0);
        chk("rst r1", 64'(result1), 64'd0);
        chk("rst carry", 64'(carry), 64'd0);
        chk("rst ovf", 64'(overflow), 64'd0);
        chk("rst zero", 64'(zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst hold r1", 64'(result1), 64'd0);

        issue(5'd0, 32'd1, 32'd2, 1'b0);
        issue(5'd3, 32'h00FF_FFFF, 32'h000E_FEFE, 1'b0);
        issue(5'd0, 32'h7FFF_FFFF, 32'h1, 1'b0);
        issue(5'd0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        issue(5'd2, 32'd5, 32'd7, 1'b0);
        issue(5'd16, 32'd5, 32'd4, 1'b1);
        issue(5'd12, 32'h8000_0000, 32'h24, 1'b0);
        issue(5'd11, 32'h8000_0000, 32'h24, 1'b0);
        issue(5'd13, 32'hFFFF_FFFF, 32'h1, 1'b0);
        issue(5'd14, 32'hFFFF_FFFF, 32'h1, 1'b0);
        issue(5'd15, 32'd100, 32'd7, 1'b0);
        issue(5'd15, 32'd9, 32'd0, 1'b0);
        issue(5'd1, 32'h7FFF_FFFF, 32'h0, 1'b1);
        issue(5'd4, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        issue(5'd31, 32'hDEAD_BEEF, 32'h1, 1'b1);

        // Mid-operation reset: the launched op must be discarded and outputs cleared at once.
        issue(5'd17, 32'h0, 32'hCAFE_F00D, 1'b0);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst r0", 64'(result0), 64'd0);
        chk("midrst ovf", 64'(overflow), 64'd0);
        @(posedge clk);
        #1;
        chk("midrst hold r0", 64'(result0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 600; i++)
            issue(5'($urandom_range(0, 31)), pick(), pick(), 1'($urandom_range(0, 1)));

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        chk("drain queue", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu32.md
Name: alu32

Overview:
- 32-bit registered integer ALU for the processor datapath.
- Takes a 5-bit opcode, two 32-bit operands and a carry-in.
- Produces a 64-bit result split into low and high words, plus carry, overflow and zero flags.
- All outputs are registered, with one-cycle latency.

Parameters:
- WIDTH, 32, operand/result word width; the opcode map and the shift-amount field (5 bits) assume 32.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  5  operation select
- operand0  input  32  operand A
- operand1  input  32  operand B
- cin  input  1  carry-in (ADDC/SUBB only)
- result0  output  32  result bits [31:0]
- result1  output  32  result bits [63:32] (multiply high word, divide remainder, else 0)
- carry  output  1  carry/borrow flag
- overflow  output  1  signed overflow flag
- zero  output  1  high when {result1,result0} == 0

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset: result0, result1, carry, overflow and zero all = 0. They stay 0 until the first rising clk after rst_n deasserts.
- Inputs are sampled every rising clk. Outputs reflect the inputs of the previous edge (latency 1, throughput 1 op/cycle, no handshake).
- Reset asserted mid-operation clears outputs immediately and discards the in-flight result.
- Opcode map (A=operand0, B=operand1):
  - 00000 ADD: A+B.
  - 00001 ADDC: A+B+cin.
  - 00010 SUB: A-B.
  - 00011 MULU: {result1,result0} = unsigned A*B, full 64 bits.
  - 00100 MULS: signed 64-bit product.
  - 00101 AND.
  - 00110 OR.
  - 00111 XOR.
  - 01000 NOR.
  - 01001 NOT A.
  - 01010 SLL: A<<B[4:0].
  - 01011 SRL: logical right shift.
  - 01100 SRA: arithmetic right shift.
  - 01101 SLT: result0 = 1 if A<B signed, else 0.
  - 01110 SLTU: result0 = 1 if A<B unsigned, else 0.
  - 01111 DIVU: only when ALU_DIV_EN is defined.
  - 10000 SUBB: A-B-cin.
  - 10001 PASSB: result0 = B.
  - All other codes are reserved.
- result1 is 0 for every opcode except MULU, MULS and DIVU.
- carry:
  - ADD/ADDC: carry-out of bit 31.
  - SUB/SUBB: borrow (1 when the unsigned A < B(+cin)).
  - All other opcodes: 0.
- overflow:
  - ADD/ADDC: operands have the same sign and the result sign differs.
  - SUB/SUBB: operands have different signs and the result sign differs from A.
  - All other opcodes: 0.
- zero is computed over the full 64-bit registered result.
- Shifts use only B[4:0]; B[31:5] is ignored.
- Reserved opcodes: result0=result1=0, carry=overflow=0, zero=1.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined: opcode 01111 is DIVU. result0 = unsigned A/B, result1 = A mod B, still one-cycle latency (combinational divider).
  - Divide-by-zero: result0=32'hFFFFFFFF, result1=A, overflow=1, carry=0.
- Undefined: 01111 behaves as a reserved opcode and no divider logic is synthesized.

Test Plan:
- Reset: hold rst_n=0 with any inputs -> all outputs 0. Release rst_n, apply ADD 1+2 -> next edge result0=32'h3, zero=0.
- MULU: operand0=32'h00FFFFFF, operand1=32'h000EFEFE, cin=0 -> result0=32'hFDF10102, result1=32'h00000EFE, carry=0, overflow=0, zero=0.
- ADD overflow: 32'h7FFFFFFF+32'h1 -> result0=32'h80000000, overflow=1, carry=0. Then FFFFFFFF+1 -> result0=0, carry=1, zero=1.
- SUB borrow: 5-7 -> result0=32'hFFFFFFFE, carry=1, overflow=0. SUBB 5-4 with cin=1 -> result0=0, zero=1, carry=0.
- Shifts: SRA 32'h80000000 by B=32'h24 (amount 4) -> 32'hF8000000. SRL same -> 32'h08000000. SLT 32'hFFFFFFFF vs 1 -> 1, SLTU -> 0.
- ALU_DIV_EN: DIVU 100/7 -> result0=14, result1=2. DIVU 9/0 -> result0=32'hFFFFFFFF, result1=9, overflow=1. Without the macro, opcode 01111 -> all zero, zero=1.
